// File: rtl/timing_sequencer_pkg.sv
// Shared definitions for the timing sequencer: opcode map, beat indices,
// FSM state encoding and opcode-class helpers.
package timing_sequencer_pkg;

   localparam int NUM_OPS   = 28;
   localparam int OP_W      = 5;
   localparam int NUM_BEATS = 8;

   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_LD_A   = 5'd0,  OP_LD_B   = 5'd1;
   localparam opcode_t OP_ADD_A  = 5'd2,  OP_ADD_B  = 5'd3,  OP_ADD_AB = 5'd4,  OP_ADD_BA = 5'd5;
   localparam opcode_t OP_SUB_A  = 5'd6,  OP_SUB_B  = 5'd7,  OP_SUB_AB = 5'd8,  OP_SUB_BA = 5'd9;
   localparam opcode_t OP_MUL_A  = 5'd10, OP_MUL_B  = 5'd11, OP_MUL_AB = 5'd12, OP_MUL_BA = 5'd13;
   localparam opcode_t OP_DIV_A  = 5'd14, OP_DIV_B  = 5'd15, OP_DIV_AB = 5'd16, OP_DIV_BA = 5'd17;
   localparam opcode_t OP_SHL_A  = 5'd18, OP_SHL_B  = 5'd19, OP_SHL_AB = 5'd20, OP_SHL_BA = 5'd21;
   localparam opcode_t OP_SHR_A  = 5'd22, OP_SHR_B  = 5'd23, OP_SHR_AB = 5'd24, OP_SHR_BA = 5'd25;
   localparam opcode_t OP_ST     = 5'd26, OP_JMP    = 5'd27;

   localparam int T0_IDX = 0, T1_IDX = 1, T2_IDX = 2, T3_IDX = 3;
   localparam int T4_IDX = 4, T5_IDX = 5, T6_IDX = 6, T7_IDX = 7;

   localparam logic [NUM_BEATS-1:0] T0_HOT = 8'b0000_0001;
   localparam logic [NUM_BEATS-1:0] T6_HOT = 8'b0100_0000;

   typedef enum logic [1:0] {IDLE, BEAT, HOLD} state_t;

   // Illegal opcodes retire early, exactly like the short loads/stores.
   function automatic logic is_short(input opcode_t op);
      return (op == OP_LD_A) || (op == OP_LD_B) || (op == OP_ST) ||
             (op == OP_JMP)  || (op > OP_JMP);
   endfunction

   function automatic logic is_multicycle(input opcode_t op);
      return (op >= OP_MUL_A) && (op <= OP_DIV_BA);
   endfunction

endpackage

// File: rtl/timing_sequencer_if.sv
// Control-unit side of the timing sequencer: run/step/IR/ALU status in,
// beats, decoded instruction lines and status out.
interface timing_sequencer_if
   import timing_sequencer_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic                 RUN;
   logic                 STEP;
   logic [7:0]           IR;
   logic                 ALU_BUSY;
   logic [NUM_BEATS-1:0] T;
   logic [NUM_OPS-1:0]   INSTR;
   logic                 RUNNING;
   logic                 FAULT;
   logic [CNT_W-1:0]     INSTR_CNT;

   modport master (
      output RUN, STEP, IR, ALU_BUSY,
      input  T, INSTR, RUNNING, FAULT, INSTR_CNT
   );

   modport slave (
      input  RUN, STEP, IR, ALU_BUSY,
      output T, INSTR, RUNNING, FAULT, INSTR_CNT
   );
endinterface

// File: rtl/timing_sequencer_instr_decode.sv
// Combinational opcode decoder: 5-bit opcode to one-hot instruction lines,
// with an illegal flag for opcodes beyond the defined map.
module instr_decode
   import timing_sequencer_pkg::*;
(
   input  opcode_t            opcode,
   output logic [NUM_OPS-1:0] onehot,
   output logic               illegal
);
   // NOTE: every combinational output gets a default first so that no path
   // through the block leaves it unassigned and infers a latch.
   always_comb begin
      onehot  = '0;
      illegal = (opcode > OP_JMP);
      if (!illegal) onehot[opcode] = 1'b1;
   end
endmodule

// File: rtl/timing_sequencer.sv
// Beat generator and opcode latch for the CPU control unit: one-hot T0..T7,
// registered decoded instruction lines, ALU stall handling and retire count.
module timing_sequencer
   import timing_sequencer_pkg::*;
#(
   parameter int SHORT_LAST = 5,
   parameter int STALL_MAX  = 15,
   parameter int CNT_W      = 8
) (
   input  logic               CLK,
   input  logic               CLRn,
   timing_sequencer_if.slave  bus
);
   localparam int STALL_W = $clog2(STALL_MAX + 1);

   state_t               state, state_nxt;
   logic [NUM_BEATS-1:0] t_q, t_nxt;
   logic [NUM_OPS-1:0]   instr_q, instr_nxt, dec_onehot;
   opcode_t              op_q, op_nxt;
   logic                 dec_illegal;
   logic                 fault_q, fault_nxt;
   logic                 step_q, step_nxt;
   logic                 running_q;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic [STALL_W-1:0]   stall_q, stall_nxt;
   logic [2:0]           last_idx;
   logic                 last_beat;

   instr_decode u_decode (
      .opcode  (bus.IR[7:3]),
      .onehot  (dec_onehot),
      .illegal (dec_illegal)
   );

   // op_q is stale during fetch, but the last beat is always past T2.
   assign last_idx  = is_short(op_q) ? 3'(SHORT_LAST) : 3'(T7_IDX);
   assign last_beat = t_q[last_idx];

   always_comb begin
      state_nxt = state;
      t_nxt     = t_q;
      instr_nxt = instr_q;
      op_nxt    = op_q;
      fault_nxt = fault_q;
      cnt_nxt   = cnt_q;
      stall_nxt = stall_q;
      step_nxt  = step_q;
      unique case (state)
         IDLE: begin
            if (bus.RUN || bus.STEP) begin
               state_nxt = BEAT;
               t_nxt     = T0_HOT;
               instr_nxt = '0;
               step_nxt  = !bus.RUN;
            end
         end
         BEAT: begin
            if (t_q[T2_IDX]) begin
               t_nxt     = t_q << 1;
               op_nxt    = bus.IR[7:3];
               instr_nxt = dec_onehot;
               if (dec_illegal) fault_nxt = 1'b1;
            end else if (last_beat) begin
               cnt_nxt   = cnt_q + 1'b1;
               instr_nxt = '0;
               if (bus.RUN && !step_q) begin
                  t_nxt = T0_HOT;
               end else begin
                  state_nxt = IDLE;
                  t_nxt     = '0;
                  step_nxt  = 1'b0;
               end
            end else if (t_q[T5_IDX] && is_multicycle(op_q) && bus.ALU_BUSY) begin
               state_nxt = HOLD;
            end else begin
               t_nxt = t_q << 1;
            end
         end
         HOLD: begin
            stall_nxt = stall_q + 1'b1;
            // Leave on ALU done, or give up after STALL_MAX extra cycles.
            if (!bus.ALU_BUSY || (stall_q == STALL_W'(STALL_MAX - 1))) begin
               if (bus.ALU_BUSY) fault_nxt = 1'b1;
               state_nxt = BEAT;
               t_nxt     = T6_HOT;
               stall_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         state     <= IDLE;
         t_q       <= '0;
         instr_q   <= '0;
         op_q      <= '0;
         fault_q   <= 1'b0;
         step_q    <= 1'b0;
         running_q <= 1'b0;
         cnt_q     <= '0;
         stall_q   <= '0;
      end else begin
         state     <= state_nxt;
         t_q       <= t_nxt;
         instr_q   <= instr_nxt;
         op_q      <= op_nxt;
         fault_q   <= fault_nxt;
         step_q    <= step_nxt;
         running_q <= (state_nxt != IDLE);
         cnt_q     <= cnt_nxt;
         stall_q   <= stall_nxt;
      end
   end

   assign bus.T         = t_q;
   assign bus.INSTR     = instr_q;
   assign bus.RUNNING   = running_q;
   assign bus.FAULT     = fault_q;
   assign bus.INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer: builds the expected per-cycle
// beat trace of each instruction from the opcode class and ALU busy length.
module tb_timing_sequencer;
   localparam int CNT_W      = 8;
   localparam int SHORT_LAST = 5;
   localparam int STALL_MAX  = 15;

   logic CLK = 1'b0;
   logic CLRn;

   timing_sequencer_if #(.CNT_W(CNT_W)) bus ();

   timing_sequencer #(
      .SHORT_LAST (SHORT_LAST),
      .STALL_MAX  (STALL_MAX),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK  (CLK),
      .CLRn (CLRn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] ir;
      int         busy_len;
   } ins_t;

   typedef struct {
      int               beat;
      logic [27:0]      instr;
      logic             fault;
      logic [CNT_W-1:0] cnt;
      logic             busy;
      logic [7:0]       ir;
   } beat_exp_t;

   ins_t             prog[$];
   beat_exp_t        exp_q[$];
   logic             m_fault;
   logic [CNT_W-1:0] m_cnt;
   int               checks = 0;
   int               errors = 0;

   function automatic logic [7:0] mk_ir(input int op);
      logic [2:0] low;
      low = 3'($urandom_range(0, 7));
      return {op[4:0], low};
   endfunction

   // Expected trace: fetch T0..T2, decode visible from T3, short classes end
   // at T5, long ones hold T5 for 1+min(busy,STALL_MAX) cycles then T6, T7.
   task automatic build_expect();
      exp_q.delete();
      foreach (prog[i]) begin
         logic [4:0] op;
         bit         legal, mc, is_sh, stall_fault;
         int         beats[$];
         int         hold_len, j;
         beat_exp_t  e;
         beats.delete();
         op          = prog[i].ir[7:3];
         legal       = (op < 28);
         mc          = (op >= 10) && (op <= 17);
         is_sh       = !legal || (op == 0) || (op == 1) || (op == 26) || (op == 27);
         stall_fault = mc && (prog[i].busy_len > STALL_MAX);
         hold_len    = mc ? 1 + ((prog[i].busy_len > STALL_MAX) ? STALL_MAX : prog[i].busy_len) : 1;
         if (is_sh) begin
            for (int x = 0; x <= SHORT_LAST; x++) beats.push_back(x);
         end else begin
            for (int x = 0; x < 5; x++) beats.push_back(x);
            for (int x = 0; x < hold_len; x++) beats.push_back(5);
            beats.push_back(6);
            beats.push_back(7);
         end
         j = 0;
         foreach (beats[p]) begin
            e.beat  = beats[p];
            e.ir    = prog[i].ir;
            e.instr = (legal && beats[p] >= 3) ? (28'd1 << op) : 28'd0;
            if (!legal && beats[p] >= 3) m_fault = 1'b1;
            if (stall_fault && beats[p] == 6) m_fault = 1'b1;
            e.fault = m_fault;
            e.cnt   = m_cnt;
            if (mc && beats[p] == 5) begin
               j++;
               e.busy = (j <= prog[i].busy_len);
            end else begin
               e.busy = 1'($urandom_range(0, 1));
            end
            exp_q.push_back(e);
         end
         m_cnt = m_cnt + 1'b1;
      end
   endtask

   task automatic run_prog(input string name, input bit use_step, input bit also_step, input bit step_mid);
      int n;
      logic [7:0] exp_t;
      build_expect();
      n = exp_q.size();
      @(negedge CLK);
      bus.RUN  = !use_step;
      bus.STEP = use_step || also_step;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         if (k == 0) bus.STEP = 1'b0;
         if (step_mid && k == 3) bus.STEP = 1'b1;
         if (step_mid && k == 4) bus.STEP = 1'b0;
         exp_t = 8'd1 << exp_q[k].beat;
         checks++;
         if (bus.T !== exp_t) begin
            errors++;
            $display("FAIL %s T cyc %0d: got %b want %b", name, k, bus.T, exp_t);
         end
         checks++;
         if (bus.INSTR !== exp_q[k].instr) begin
            errors++;
            $display("FAIL %s INSTR cyc %0d: got %h want %h", name, k, bus.INSTR, exp_q[k].instr);
         end
         checks++;
         if (bus.RUNNING !== 1'b1) begin
            errors++;
            $display("FAIL %s RUNNING cyc %0d: got %b want 1", name, k, bus.RUNNING);
         end
         checks++;
         if (bus.FAULT !== exp_q[k].fault) begin
            errors++;
            $display("FAIL %s FAULT cyc %0d: got %b want %b", name, k, bus.FAULT, exp_q[k].fault);
         end
         checks++;
         if (bus.INSTR_CNT !== exp_q[k].cnt) begin
            errors++;
            $display("FAIL %s INSTR_CNT cyc %0d: got %0d want %0d", name, k, bus.INSTR_CNT, exp_q[k].cnt);
         end
         bus.ALU_BUSY = exp_q[k].busy;
         bus.IR       = exp_q[k].ir;
         if (k == n - 1) bus.RUN = 1'b0;
      end
      @(negedge CLK);
      checks++;
      if (bus.T !== 8'd0 || bus.RUNNING !== 1'b0 || bus.INSTR !== 28'd0) begin
         errors++;
         $display("FAIL %s idle: got T=%b RUNNING=%b INSTR=%h want 0/0/0", name, bus.T, bus.RUNNING, bus.INSTR);
      end
      checks++;
      if (bus.INSTR_CNT !== m_cnt || bus.FAULT !== m_fault) begin
         errors++;
         $display("FAIL %s idle status: got CNT=%0d FAULT=%b want %0d/%b", name, bus.INSTR_CNT, bus.FAULT, m_cnt, m_fault);
      end
      prog.delete();
   endtask

   task automatic test_reset();
      CLRn = 1'b0;
      bus.RUN = 1'b0; bus.STEP = 1'b0; bus.IR = 8'h00; bus.ALU_BUSY = 1'b0;
      m_fault = 1'b0; m_cnt = '0;
      @(negedge CLK);
      checks++;
      if (bus.T !== 8'd0 || bus.INSTR !== 28'd0 || bus.RUNNING !== 1'b0 ||
          bus.FAULT !== 1'b0 || bus.INSTR_CNT !== '0) begin
         errors++;
         $display("FAIL reset: got T=%b INSTR=%h RUNNING=%b FAULT=%b CNT=%0d want all 0",
                  bus.T, bus.INSTR, bus.RUNNING, bus.FAULT, bus.INSTR_CNT);
      end
      CLRn = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.T !== 8'd0 || bus.RUNNING !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got T=%b RUNNING=%b want 0/0", bus.T, bus.RUNNING);
      end
   endtask

   task automatic test_ld_a();
      prog.push_back('{ir: 8'h00, busy_len: 0});
      prog.push_back('{ir: 8'h00, busy_len: 0});
      run_prog("ld_a", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      prog.push_back('{ir: 8'h10, busy_len: 0});
      prog.push_back('{ir: mk_ir(2), busy_len: 0});
      prog.push_back('{ir: mk_ir(7), busy_len: 0});
      prog.push_back('{ir: mk_ir(20), busy_len: 0});
      prog.push_back('{ir: mk_ir(25), busy_len: 0});
      prog.push_back('{ir: mk_ir(26), busy_len: 0});
      prog.push_back('{ir: mk_ir(27), busy_len: 0});
      prog.push_back('{ir: mk_ir(1), busy_len: 0});
      run_prog("back_to_back", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_mul_stall();
      prog.push_back('{ir: 8'h60, busy_len: 3});
      prog.push_back('{ir: mk_ir(10), busy_len: 0});
      prog.push_back('{ir: mk_ir(17), busy_len: STALL_MAX});
      prog.push_back('{ir: mk_ir(4), busy_len: 9});
      run_prog("mul_stall", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_run_step_priority();
      prog.push_back('{ir: mk_ir(3), busy_len: 0});
      prog.push_back('{ir: mk_ir(0), busy_len: 0});
      run_prog("run_beats_step", 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_step_ignored();
      prog.push_back('{ir: mk_ir(6), busy_len: 0});
      prog.push_back('{ir: mk_ir(22), busy_len: 0});
      run_prog("step_ignored", 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_div_timeout();
      prog.push_back('{ir: 8'h70, busy_len: 100});
      prog.push_back('{ir: 8'h00, busy_len: 0});
      run_prog("div_timeout", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
      prog.push_back('{ir: 8'hF8, busy_len: 0});
      prog.push_back('{ir: 8'hE3, busy_len: 0});
      prog.push_back('{ir: mk_ir(1), busy_len: 0});
      run_prog("illegal", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         int b;
         b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
         prog.push_back('{ir: 8'($urandom_range(0, 255)), busy_len: b});
      end
      run_prog("random", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 260; i++) begin
         int pick;
         pick = int'($urandom_range(0, 3));
         prog.push_back('{ir: mk_ir(pick < 2 ? pick : pick + 24), busy_len: 0});
      end
      run_prog("cnt_wrap", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_step_and_reset();
      logic [7:0] exp_t;
      prog.push_back('{ir: mk_ir(3), busy_len: 0});
      run_prog("single_step", 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.T !== 8'd0 || bus.RUNNING !== 1'b0) begin
         errors++;
         $display("FAIL step_stays_idle: got T=%b RUNNING=%b want 0/0", bus.T, bus.RUNNING);
      end
      bus.IR  = 8'h10;
      bus.RUN = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(negedge CLK);
         exp_t = 8'd1 << k;
         checks++;
         if (bus.T !== exp_t) begin
            errors++;
            $display("FAIL pre_reset T cyc %0d: got %b want %b", k, bus.T, exp_t);
         end
      end
      CLRn = 1'b0;
      #1;
      checks++;
      if (bus.T !== 8'd0 || bus.INSTR !== 28'd0 || bus.RUNNING !== 1'b0 ||
          bus.FAULT !== 1'b0 || bus.INSTR_CNT !== '0) begin
         errors++;
         $display("FAIL async_reset: got T=%b INSTR=%h RUNNING=%b FAULT=%b CNT=%0d want all 0",
                  bus.T, bus.INSTR, bus.RUNNING, bus.FAULT, bus.INSTR_CNT);
      end
      m_fault = 1'b0;
      m_cnt   = '0;
      bus.RUN = 1'b0;
      @(negedge CLK);
      CLRn = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.T !== 8'd0 || bus.RUNNING !== 1'b0 || bus.INSTR_CNT !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got T=%b RUNNING=%b CNT=%0d want 0/0/0", bus.T, bus.RUNNING, bus.INSTR_CNT);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_ld_a();
      test_back_to_back();
      test_mul_stall();
      test_run_step_priority();
      test_step_ignored();
      test_div_timeout();
      test_illegal();
      test_random();
      test_wrap();
      test_step_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
